fractal_sync_br_tx: RTL

FRACTAL_SYNC_BR_TX -- requirements
Module: fractal_sync_br_tx

---
 rtl/fractal_sync_pkg.sv | 14 +
 rtl/fractal_sync_br_fifo.sv | 71 +++++++
 rtl/fractal_sync_br_tx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fractal_sync_pkg.sv
// fractal_sync_pkg
//   Shared constants and types for the fractal sync network.
//   SD_WIDTH      : number of back-route ports addressed by a source/destination mask.
//   br_tx_state_e : state of the barrier-response transmitter.
package fractal_sync_pkg;

    localparam int SD_WIDTH = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } br_tx_state_e;

endpackage

// File: rtl/fractal_sync_br_fifo.sv
// fractal_sync_br_fifo
//   Circular buffer of completed barrier events. It exposes both the head and
//   the entry behind it, so the transmitter can reload its pending mask in the
//   same cycle that it retires the head.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write data_i (ignored when full)
//   pop_i         : drop the head (ignored when empty)
//   full_o        : FIFO full
//   empty_o       : FIFO empty
//   level_o       : number of stored entries
//   head_o        : oldest entry
//   next_o        : entry behind the head (meaningful only when level_o > 1)
module fractal_sync_br_fifo #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 4,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [LVL_W-1:0]      level_o,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [DATA_WIDTH-1:0] next_o
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [LVL_W-1:0]      r_cnt;
    logic [PTR_W-1:0]      w_rptr_nxt;
    logic                  w_push;
    logic                  w_pop;

    assign w_push     = push_i & ~full_o;
    assign w_pop      = pop_i & ~empty_o;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    assign w_rptr_nxt = r_rptr + 1'b1;

    assign full_o  = (r_cnt == LVL_W'(DEPTH));
    assign empty_o = (r_cnt == '0);
    assign level_o = r_cnt;
    assign head_o  = r_mem[r_rptr];
    assign next_o  = r_mem[w_rptr_nxt];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= w_rptr_nxt;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/fractal_sync_br_tx.sv
// fractal_sync_br_tx
//   Barrier-response transmitter. Completed barrier events are queued; the
//   head event is broadcast to every back-route port named in its sd mask,
//   each port handshaking independently. The head retires once all of its
//   ports have accepted it, and the next event follows without a bubble.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   evt_valid_i/evt_ready_o, evt_sig_i, evt_sd_i : event input
//   rsp_valid_o[p]/rsp_ready_i[p], rsp_sig_o[p]  : per-port response
//   busy_o          : queue non-empty or a response in flight
//   level_o         : queued events, including the one being sent
module fractal_sync_br_tx
    import fractal_sync_pkg::*;
#(
    parameter  int SIG_WIDTH  = 1,
    parameter  int FIFO_DEPTH = 4,
    localparam int SD_WIDTH   = fractal_sync_pkg::SD_WIDTH,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                evt_valid_i,
    output logic                                evt_ready_o,
    input  logic [SIG_WIDTH-1:0]                evt_sig_i,
    input  logic [SD_WIDTH-1:0]                 evt_sd_i,
    output logic [SD_WIDTH-1:0]                 rsp_valid_o,
    input  logic [SD_WIDTH-1:0]                 rsp_ready_i,
    output logic [SD_WIDTH-1:0][SIG_WIDTH-1:0]  rsp_sig_o,
    output logic                                busy_o,
    output logic [LVL_W-1:0]                    level_o
);

    localparam int DW = SIG_WIDTH + SD_WIDTH;

    br_tx_state_e          r_state, w_state_nxt;
    logic [SD_WIDTH-1:0]   r_pend, w_pend_nxt;
    logic [SD_WIDTH-1:0]   w_hs;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [LVL_W-1:0]      w_level;
    logic [DW-1:0]         w_head;
    logic [DW-1:0]         w_next;
    logic [SD_WIDTH-1:0]   w_head_sd;
    logic [SD_WIDTH-1:0]   w_next_sd;
    logic [SIG_WIDTH-1:0]  w_head_sig;

    fractal_sync_br_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (evt_valid_i),
        .pop_i   (w_pop),
        .data_i  ({evt_sig_i, evt_sd_i}),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (w_level),
        .head_o  (w_head),
        .next_o  (w_next)
    );

    assign w_head_sd  = w_head[SD_WIDTH-1:0];
    assign w_head_sig = w_head[DW-1:SD_WIDTH];
    assign w_next_sd  = w_next[SD_WIDTH-1:0];

    // Ready depends on fullness alone, so a same-cycle pop never frees a slot.
    assign evt_ready_o = ~w_full;
    assign level_o     = w_level;
    assign busy_o      = ~w_empty | (r_state == SEND);

    // pend is only non-zero in SEND, so it doubles as the valid vector.
    assign rsp_valid_o = r_pend;
    assign w_hs        = r_pend & rsp_ready_i;

    always_comb begin
        for (int p = 0; p < SD_WIDTH; p++) begin
            rsp_sig_o[p] = r_pend[p] ? w_head_sig : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    if (w_head_sd != '0) begin
                        w_pend_nxt  = w_head_sd;
                        w_state_nxt = SEND;
                    end else begin
                        // Barrier with no back-route ports: retire silently.
                        w_pop = 1'b1;
                    end
                end
            end
            SEND: begin
                w_pend_nxt = r_pend & ~w_hs;
                if (w_pend_nxt == '0) begin
                    w_pop = 1'b1;
                    // Chain straight into the next entry; an empty-mask
                    // successor is dropped from IDLE on the following cycle.
                    if (w_level > LVL_W'(1) && w_next_sd != '0) begin
                        w_pend_nxt = w_next_sd;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pend_nxt  = '0;
            end
        endcase
    end

endmodule
